// File: rtl/regfile_write_queue_pkg.sv
// Shared defaults for the register-file write queue. These widths match the
// register file's write index and data, so both sides take them from here.
package regfile_write_queue_pkg;

    localparam int DEPTH_DEF    = 4;
    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 64;
    localparam int NUM_REGS_DEF = 64;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Bus bundle for the write queue: the producer side, the register-file drain
// side, the bypass lookup and the status outputs.
interface regfile_write_queue_if
    import regfile_write_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    // Producer handshake
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;

    // Register-file side
    logic              drain_en;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              reg_write;
    logic              En;

    // Bypass lookup
    logic [ADDR_W-1:0] lookup_reg;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    // Status
    logic [CW-1:0]     count;
    logic              drop_err;

    // Environment driving the queue
    modport master (
        output wb_valid, wb_reg, wb_data, drain_en, lookup_reg,
        input  wb_ready, write_reg, write_data, reg_write, En,
               hit, hit_data, count, drop_err
    );

    // The queue itself
    modport slave (
        input  wb_valid, wb_reg, wb_data, drain_en, lookup_reg,
        output wb_ready, write_reg, write_data, reg_write, En,
               hit, hit_data, count, drop_err
    );

endinterface

// File: rtl/regfile_write_queue_wq_match.sv
// Bypass lookup: compares every pending entry against the lookup index and
// returns the data of the newest match. Entries are examined by age (offset
// from head) so that validity and newest-wins priority are both simple.
module wq_match
    import regfile_write_queue_pkg::*;
#(
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  ADDR_W = ADDR_W_DEF,
    parameter int  DATA_W = DATA_W_DEF,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic [ADDR_W-1:0] ent_reg  [DEPTH],
    input  logic [DATA_W-1:0] ent_data [DEPTH],
    input  logic [PW-1:0]     head,
    input  logic [CW-1:0]     count,
    input  logic [ADDR_W-1:0] lookup_reg,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic [PW-1:0]     slot_idx  [DEPTH];
    logic              age_match [DEPTH];
    logic [DATA_W-1:0] age_data  [DEPTH];

    // Age gi lives at head+gi; it only counts if it is within the pending range,
    // which keeps stale storage from ever matching.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign slot_idx[gi]  = head + PW'(gi);
        assign age_match[gi] = (CW'(gi) < count) && (ent_reg[slot_idx[gi]] == lookup_reg);
        assign age_data[gi]  = ent_data[slot_idx[gi]];
    end

    // Scan oldest to newest so the last match seen (the newest write) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (age_match[k]) begin
                hit      = 1'b1;
                hit_data = age_data[k];
            end
        end
    end

endmodule

// File: rtl/regfile_write_queue.sv
// Pending-write queue in front of the register file. Writes are held in a
// circular FIFO, drained one per cycle when the register file allows, and
// can be read back through a newest-match bypass lookup. Out-of-range
// indices are consumed and flagged with a one-cycle drop_err pulse.
module regfile_write_queue
    import regfile_write_queue_pkg::*;
#(
    parameter int  DEPTH    = DEPTH_DEF,
    parameter int  ADDR_W   = ADDR_W_DEF,
    parameter int  DATA_W   = DATA_W_DEF,
    parameter int  NUM_REGS = NUM_REGS_DEF,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    regfile_write_queue_if.slave bus
);

    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [ADDR_W:0] NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;

    // Entry storage; not reset, validity comes solely from head/count.
    logic [ADDR_W-1:0] ent_reg_q  [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];

    logic wb_ready;
    logic accept;
    logic in_range;
    logic push;
    logic pop;

    // Handshake decode and next-state pointer/count arithmetic.
    always_comb begin
        // No pass-through when full: readiness depends on current count only.
        wb_ready = (count_q < DEPTH_C);
        accept   = bus.wb_valid && wb_ready;
        in_range = ({1'b0, bus.wb_reg} < NUM_REGS_C);
        push     = accept && in_range;
        pop      = (count_q != '0) && bus.drain_en;

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        drop_d = accept && !in_range;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Write accepted entries at the tail.
    always_ff @(posedge Clk) begin
        if (push) begin
            ent_reg_q[tail_q]  <= bus.wb_reg;
            ent_data_q[tail_q] <= bus.wb_data;
        end
    end

    wq_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_match (
        .ent_reg    (ent_reg_q),
        .ent_data   (ent_data_q),
        .head       (head_q),
        .count      (count_q),
        .lookup_reg (bus.lookup_reg),
        .hit        (bus.hit),
        .hit_data   (bus.hit_data)
    );

    assign bus.wb_ready   = wb_ready;
    assign bus.reg_write  = pop;
    assign bus.En         = pop;
    assign bus.write_reg  = pop ? ent_reg_q[head_q]  : '0;
    assign bus.write_data = pop ? ent_data_q[head_q] : '0;
    assign bus.count      = count_q;
    assign bus.drop_err   = drop_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench for regfile_write_queue: a driver applies directed and
// random cycles and predicts each cycle's outputs from a queue-based model;
// a monitor pops those predictions and compares against the DUT.
module tb_regfile_write_queue;

    localparam int DEPTH    = 4;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 64;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    typedef struct {
        bit                skip;
        bit                rdy;
        int                cnt;
        bit                rw;
        bit                hit;
        logic [DATA_W-1:0] hd;
        bit                drop;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_write_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    ent_t pend[$];     // model: pending entries, oldest first
    ent_t wr_exp[$];   // expected register-file write stream
    rec_t recq[$];     // per-cycle expected outputs
    bit   drop_flag;
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, predict outputs, then advance the model at the edge.
    task automatic step(input bit v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                        input bit dr, input logic [ADDR_W-1:0] lk, input bit rs, input bit skip);
        rec_t rec;
        ent_t e;
        bit   acc;
        @(negedge clk);
        #1;
        rst            = rs;
        bus.wb_valid   = v;
        bus.wb_reg     = r;
        bus.wb_data    = d;
        bus.drain_en   = dr;
        bus.lookup_reg = lk;

        rec.skip = skip;
        rec.cnt  = pend.size();
        rec.rdy  = pend.size() < DEPTH;
        rec.rw   = (pend.size() != 0) && dr;
        rec.drop = drop_flag;
        rec.hit  = 1'b0;
        rec.hd   = '0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].r == lk) begin
                rec.hit = 1'b1;
                rec.hd  = pend[i].d;
                break;
            end
        end
        recq.push_back(rec);
        n_vec++;

        @(posedge clk);
        if (rs) begin
            pend.delete();
            wr_exp.delete();
            drop_flag = 1'b0;
        end else begin
            acc = v && (pend.size() < DEPTH);
            if (rec.rw) void'(pend.pop_front());
            e.r = r;
            e.d = d;
            if (acc && (int'(r) < NUM_REGS)) begin
                pend.push_back(e);
                wr_exp.push_back(e);
            end
            drop_flag = acc && (int'(r) >= NUM_REGS);
        end
    endtask

    task automatic idle(input bit dr, input logic [ADDR_W-1:0] lk, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, dr, lk, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d,
                        input bit dr, input logic [ADDR_W-1:0] lk);
        step(1'b1, r, d, dr, lk, 1'b0, 1'b0);
    endtask

    // Monitor: compares DUT outputs mid-cycle against the predicted record.
    initial begin
        rec_t rec;
        ent_t e;
        forever begin
            @(negedge clk);
            #3;
            if (recq.size() != 0) begin
                rec = recq.pop_front();
                if (!rec.skip) begin
                    chk("count",     64'(bus.count),    64'(rec.cnt));
                    chk("wb_ready",  64'(bus.wb_ready), 64'(rec.rdy));
                    chk("reg_write", 64'(bus.reg_write), 64'(rec.rw));
                    chk("En",        64'(bus.En),       64'(rec.rw));
                    chk("hit",       64'(bus.hit),      64'(rec.hit));
                    chk("hit_data",  bus.hit_data,      rec.hd);
                    chk("drop_err",  64'(bus.drop_err), 64'(rec.drop));
                    if (bus.reg_write === 1'b1) begin
                        if (wr_exp.size() == 0) begin
                            chk("write_unexpected", 64'd1, 64'd0);
                        end else begin
                            e = wr_exp.pop_front();
                            chk("write_reg",  64'(bus.write_reg), 64'(e.r));
                            chk("write_data", bus.write_data,     e.d);
                        end
                    end else begin
                        chk("write_reg_idle",  64'(bus.write_reg), 64'd0);
                        chk("write_data_idle", bus.write_data,     64'd0);
                    end
                end
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] r;
        bus.wb_valid   = 1'b0;
        bus.wb_reg     = '0;
        bus.wb_data    = '0;
        bus.drain_en   = 1'b0;
        bus.lookup_reg = '0;
        drop_flag      = 1'b0;

        // Power-up reset (state unknown, not checked), then a checked reset cycle.
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b1, '0, 1'b1, 1'b0);

        // Basic push and drain.
        push(8'd5, 64'hAAAA, 1'b1, 8'd5);
        idle(1'b1, 8'd5, 2);

        // Fill to full, refused 5th write, then drain in order.
        for (int i = 1; i <= 4; i++) push(8'(i), 64'(100 + i), 1'b0, 8'd3);
        push(8'd9, 64'h99, 1'b0, 8'd9);
        idle(1'b1, 8'd2, 5);

        // Simultaneous push/pop at count=2 across tail wraps.
        push(8'd10, 64'h1010, 1'b0, 8'd10);
        push(8'd11, 64'h1111, 1'b0, 8'd11);
        for (int i = 0; i < 10; i++) push(8'(12 + i), 64'(32'hC000 + i), 1'b1, 8'(12 + i));
        idle(1'b1, 8'd0, 3);

        // Newest-match bypass, then no hit once drained.
        push(8'd7, 64'h11, 1'b0, 8'd7);
        push(8'd7, 64'h22, 1'b0, 8'd7);
        idle(1'b0, 8'd7, 2);
        idle(1'b1, 8'd7, 3);

        // Out-of-range write at the boundary, then the last valid index.
        push(8'd64, 64'hDEAD, 1'b0, 8'd64);
        idle(1'b0, 8'd64, 2);
        push(8'd63, 64'hBEEF, 1'b0, 8'd63);
        idle(1'b1, 8'd63, 2);

        // Reset mid-operation with drain enabled.
        push(8'd1, 64'hA1, 1'b0, 8'd2);
        push(8'd2, 64'hA2, 1'b0, 8'd2);
        push(8'd3, 64'hA3, 1'b0, 8'd2);
        step(1'b0, '0, '0, 1'b1, 8'd2, 1'b1, 1'b0);
        idle(1'b1, 8'd2, 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r = 8'($urandom_range(60, 255));
            else                           r = 8'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 7, r, {$urandom, $urandom},
                 $urandom_range(0, 1) == 1, 8'($urandom_range(0, 8)),
                 $urandom_range(0, 99) < 2, 1'b0);
        end
        idle(1'b1, 8'd0, 6);

        @(negedge clk);
        #4;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of pending-write entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 8: register index width.
REQ-003 Parameter DATA_W, default 64: write data width.
REQ-004 Parameter NUM_REGS, default 64: number of valid register indices, 0..NUM_REGS-1.
REQ-005 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-006 Rst  input  1  reset; synchronous, active-high.
REQ-007 wb_valid  input  1  producer offers a write.
REQ-008 wb_ready  output  1  queue can accept a write this cycle.
REQ-009 wb_reg  input  ADDR_W  destination register index.
REQ-010 wb_data  input  DATA_W  write data.
REQ-011 drain_en  input  1  downstream register file may accept a write this cycle.
REQ-012 write_reg  output  ADDR_W  index driven to the register file.
REQ-013 write_data  output  DATA_W  data driven to the register file.
REQ-014 reg_write  output  1  write strobe to the register file.
REQ-015 En  output  1  register-file enable; always equal to reg_write.
REQ-016 lookup_reg  input  ADDR_W  bypass query index.
REQ-017 hit  output  1  a pending entry matches lookup_reg.
REQ-018 hit_data  output  DATA_W  data of the newest matching pending entry.
REQ-019 count  output  $clog2(DEPTH)+1  number of pending entries.
REQ-020 drop_err  output  1  one-cycle pulse: an out-of-range write was discarded.

Function
REQ-021 Pending entries are kept in circular FIFO order, with head and tail pointers that wrap modulo DEPTH.
REQ-022 wb_ready shall be 1 exactly when count < DEPTH; there is no pass-through when full, even if a pop happens in the same cycle.
REQ-023 A push occurs when wb_valid && wb_ready && wb_reg < NUM_REGS; the entry {wb_reg, wb_data} is stored at the tail.
REQ-024 When wb_valid && wb_ready && wb_reg >= NUM_REGS, the write is consumed and not stored, and drop_err is 1 on the following cycle only.
REQ-025 reg_write shall be high when count != 0 && drain_en (combinational).
REQ-026 When reg_write is high, write_reg and write_data are the head entry; otherwise both are 0.
REQ-027 A pop occurs on any posedge with reg_write high; the head advances, so each entry reaches the register file in exactly one cycle.
REQ-028 A push and a pop in the same cycle leave count unchanged; the order of entries is preserved.
REQ-029 Latency: an entry pushed into an empty queue is presented on reg_write in the next cycle, given drain_en.
REQ-030 hit is computed combinationally over stored entries only; the current wb_* inputs are not included.
REQ-031 On multiple matches, hit_data is the entry closest to the tail (the newest write).
REQ-032 hit is 0 and hit_data is 0 when count == 0 or there is no match.
REQ-033 The head entry is searched for hit even while it is being popped; the register file holds the value from the next cycle onward.
REQ-034 count never exceeds DEPTH and never underflows.

Reset
REQ-035 When Rst is high at a posedge: head, tail and count are 0, and drop_err is 0.
REQ-036 Reset mid-operation discards all pending entries; reg_write is 0 from the next cycle, even if drain_en is high.
REQ-037 Entry storage need not be cleared by reset, but no stale entry may produce hit or reg_write.

Structure
REQ-038 A shared package holds ADDR_W, DATA_W and NUM_REGS defaults so they match the register file's read/write index and data widths.
REQ-039 One sub-module, wq_match, holds the DEPTH-way compare and newest-match priority select for the bypass lookup.

Verification
REQ-040 Basic push and drain: push reg 5 = 0xAAAA, drain_en=1 -> the next cycle shows reg_write=1, write_reg=5, write_data=0xAAAA, En=1, then count=0.
REQ-041 Fill and full: drain_en=0, push 4 entries (regs 1..4) -> count=4, wb_ready=0; a 5th wb_valid is not accepted; drain_en=1 -> regs 1,2,3,4 are written on 4 consecutive cycles.
REQ-042 Simultaneous push and pop: count=2 with a push and a pop in one cycle -> count stays 2; the FIFO order is checked across a tail wrap (10 pushes through DEPTH=4).
REQ-043 Newest-match bypass: push reg 7 = 0x11, then reg 7 = 0x22, drain_en=0, lookup_reg=7 -> hit=1, hit_data=0x22; after both drain -> hit=0.
REQ-044 Out-of-range write: push wb_reg=64 -> drop_err=1 for one cycle, count unchanged, no reg_write.
REQ-045 Reset mid-operation: 3 entries pending and Rst pulsed one cycle with drain_en=1 -> count=0, reg_write=0, hit=0 afterwards.
